ps2_scan_ctrl: RTL and testbench

Controller that sequences the PS/2 keyboard receiver's FIFO. It pops bytes with the ready/nextdata_n handshake and parses make/break/extended scan-code sequences into key events. It also maintains a key-press counter, recovers from receiver overflow, and drives the seven-segment select mask. It sits between ps2_keyboard and digital_led in the top level, replacing ad-hoc handshake logic.

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_code_parser.sv | 47 ++++
 rtl/ps2_scan_ctrl.sv | 118 +++++++++++
 tb/tb_ps2_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code controller.
// Holds the handshake FSM state encoding, the prefix bytes and the display select masks.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    SETTLE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [7:0] PS2_BREAK    = 8'hF0;
  localparam logic [7:0] PS2_EXT      = 8'hE0;
  localparam logic [7:0] SEG_SEL_HELD = 8'h33;
  localparam logic [7:0] SEG_SEL_IDLE = 8'h30;

endpackage

// File: rtl/ps2_code_parser.sv
// Scan-code prefix tracker and classifier: the brk/ext flags update on each popped byte.
// The make/break classification is combinational in the same cycle as byte_vld; there is no backpressure.
import ps2_pkg::*;

module ps2_code_parser (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       byte_vld,
  input  logic [7:0] byte_dat,
  input  logic [7:0] key_code,
  input  logic       key_ext,
  input  logic       key_valid,
  output logic       code_ext,
  output logic       is_make,
  output logic       is_break
);

  logic brk;
  logic ext;
  logic is_code;
  logic held_match;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (byte_vld) begin
      if (byte_dat == PS2_BREAK) begin
        brk <= 1'b1;
      end else if (byte_dat == PS2_EXT) begin
        ext <= 1'b1;
      end else begin
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end
  end

  assign is_code    = byte_vld && (byte_dat != PS2_BREAK) && (byte_dat != PS2_EXT);
  // A held key matches only if the extended flag agrees too, so E0 75 and a bare 75 are different keys.
  assign held_match = key_valid && (byte_dat == key_code) && (ext == key_ext);
  assign code_ext   = ext;
  assign is_break   = is_code && brk && held_match;
  assign is_make    = is_code && !brk && !held_match;

endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 receiver FIFO sequencer: pops one byte every 3 cycles and turns scan codes into key events and a press count.
// Event pulses appear one cycle after the pop; ps2_ready is the only flow control, and an overflow clears the receiver.
import ps2_pkg::*;

module ps2_scan_ctrl #(
  parameter int CNT_W      = 8,
  parameter int CLR_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             ps2_nextdata_n,
  output logic             ps2_clrn,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_valid,
  output logic             make_pulse,
  output logic             break_pulse,
  output logic [CNT_W-1:0] press_count,
  output logic [7:0]       seg_select
);

  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  state_t           state;
  state_t           state_nx;
  logic [CLR_W-1:0] clr_cnt;
  logic [7:0]       byte_q;
  logic             code_ext;
  logic             is_make;
  logic             is_break;

  ps2_code_parser u_parser (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == RECOVER),
    .byte_vld  (state == POP),
    .byte_dat  (byte_q),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_valid (key_valid),
    .code_ext  (code_ext),
    .is_make   (is_make),
    .is_break  (is_break)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (ps2_overflow) begin
          state_nx = RECOVER;
        end else if (ps2_ready) begin
          state_nx = POP;
        end
      end
      POP:     state_nx = SETTLE;
      SETTLE:  state_nx = IDLE;
      RECOVER: begin
        if (clr_cnt <= CLR_W'(1)) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = RECOVER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RECOVER;
      clr_cnt <= CLR_W'(CLR_CYCLES);
      byte_q  <= 8'h00;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == RECOVER) begin
        clr_cnt <= CLR_W'(CLR_CYCLES);
      end else if (state == RECOVER) begin
        clr_cnt <= clr_cnt - CLR_W'(1);
      end
      if (state == IDLE && state_nx == POP) begin
        byte_q <= ps2_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_valid   <= 1'b0;
      make_pulse  <= 1'b0;
      break_pulse <= 1'b0;
      press_count <= '0;
      seg_select  <= SEG_SEL_IDLE;
    end else begin
      make_pulse  <= is_make;
      break_pulse <= is_break;
      seg_select  <= key_valid ? SEG_SEL_HELD : SEG_SEL_IDLE;
      if (state == RECOVER) begin
        key_valid <= 1'b0;
      end else if (is_make) begin
        key_code    <= byte_q;
        key_ext     <= code_ext;
        key_valid   <= 1'b1;
        press_count <= press_count + CNT_W'(1);
      end else if (is_break) begin
        key_valid <= 1'b0;
      end
    end
  end

  // Reset is folded in so the receiver is held cleared and never popped while reset is asserted.
  assign ps2_nextdata_n = reset || (state != POP);
  assign ps2_clrn       = !(reset || (state == RECOVER));

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Directed bench for ps2_scan_ctrl with a queue-based receiver model and monitors that count events.
module tb_ps2_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       ps2_overflow = 1'b0;
  logic       ps2_nextdata_n;
  logic       ps2_clrn;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_valid;
  logic       make_pulse;
  logic       break_pulse;
  logic [7:0] press_count;
  logic [7:0] seg_select;

  logic [7:0] q[$];
  int         pop_cyc[$];
  int         cyc = 0;
  int         clr_low = 0;
  int         make_cnt = 0;
  int         break_cnt = 0;
  int         pop_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  ps2_scan_ctrl #(.CNT_W(8), .CLR_CYCLES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ps2_data       (ps2_data),
    .ps2_ready      (ps2_ready),
    .ps2_overflow   (ps2_overflow),
    .ps2_nextdata_n (ps2_nextdata_n),
    .ps2_clrn       (ps2_clrn),
    .key_code       (key_code),
    .key_ext        (key_ext),
    .key_valid      (key_valid),
    .make_pulse     (make_pulse),
    .break_pulse    (break_pulse),
    .press_count    (press_count),
    .seg_select     (seg_select)
  );

  always #5 clk = ~clk;

  // Receiver model: a cleared receiver drops its FIFO, a pop strobe removes the head byte.
  always @(negedge clk) begin
    cyc++;
    if (!ps2_clrn) begin
      clr_low++;
      q.delete();
    end
    if (make_pulse) make_cnt++;
    if (break_pulse) break_cnt++;
    if (!ps2_nextdata_n) begin
      pop_cnt++;
      pop_cyc.push_back(cyc);
      if (q.size() > 0) void'(q.pop_front());
    end
    ps2_ready = (q.size() != 0);
    ps2_data  = (q.size() != 0) ? q[0] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    make_cnt  = 0;
    break_cnt = 0;
    pop_cnt   = 0;
    clr_low   = 0;
    pop_cyc.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check({tag, "_timeout"}, 32'(q.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int nb);
    q.push_back(b0);
    if (nb > 1) q.push_back(b1);
    if (nb > 2) q.push_back(b2);
    drain(tag);
  endtask

  initial begin
    int n;
    logic [7:0] code;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_nextdata_n", ps2_nextdata_n, 1'b1);
    check("rst_clrn", ps2_clrn, 1'b0);
    check("rst_key_code", key_code, 8'h00);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_press_count", press_count, 8'd0);
    check("rst_seg_select", seg_select, 8'h30);
    check("rst_pulses", {make_pulse, break_pulse}, 2'b00);
    reset = 1'b0;
    clr_low = 0;
    repeat (8) @(negedge clk);
    check("rst_clr_cycles", 32'(clr_low), 32'd4);
    check("rst_clrn_released", ps2_clrn, 1'b1);

    // Basic make then break
    clear_counts();
    send("make1c", 8'h1C, 8'h00, 8'h00, 1);
    check("make1c_pulses", 32'(make_cnt), 32'd1);
    check("make1c_code", key_code, 8'h1C);
    check("make1c_ext", key_ext, 1'b0);
    check("make1c_valid", key_valid, 1'b1);
    check("make1c_count", press_count, 8'd1);
    check("make1c_seg", seg_select, 8'h33);
    clear_counts();
    send("brk1c", 8'hF0, 8'h1C, 8'h00, 2);
    check("brk1c_pulses", 32'(break_cnt), 32'd1);
    check("brk1c_make", 32'(make_cnt), 32'd0);
    check("brk1c_valid", key_valid, 1'b0);
    check("brk1c_seg", seg_select, 8'h30);
    check("brk1c_code_kept", key_code, 8'h1C);

    // Typematic repeats do not count
    clear_counts();
    q.push_back(8'h1C); q.push_back(8'h1C);
    send("typ", 8'h1C, 8'hF0, 8'h1C, 3);
    check("typ_make", 32'(make_cnt), 32'd1);
    check("typ_break", 32'(break_cnt), 32'd1);
    check("typ_count", press_count, 8'd2);
    check("typ_pops", 32'(pop_cnt), 32'd5);

    // Back-to-back queued bytes: one pop each, spaced 3 cycles apart
    clear_counts();
    send("hs", 8'h1D, 8'hF0, 8'h1D, 3);
    check("hs_pops", 32'(pop_cnt), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("hs_gap0", 32'(pop_cyc[1] - pop_cyc[0]), 32'd3);
      check("hs_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd3);
    end
    check("hs_count", press_count, 8'd3);
    check("hs_valid", key_valid, 1'b0);

    // Extended key, bare break ignored, extended break releases
    clear_counts();
    send("ext_make", 8'hE0, 8'h75, 8'h00, 2);
    check("ext_code", key_code, 8'h75);
    check("ext_flag", key_ext, 1'b1);
    check("ext_count", press_count, 8'd4);
    check("ext_make_pulse", 32'(make_cnt), 32'd1);
    send("ext_bare", 8'hF0, 8'h75, 8'h00, 2);
    check("ext_bare_valid", key_valid, 1'b1);
    check("ext_bare_break", 32'(break_cnt), 32'd0);
    send("ext_brk", 8'hE0, 8'hF0, 8'h75, 3);
    check("ext_brk_valid", key_valid, 1'b0);
    check("ext_brk_pulse", 32'(break_cnt), 32'd1);
    check("ext_brk_count", press_count, 8'd4);

    // Overflow recovery with a pending break prefix
    send("ov_make", 8'h1C, 8'h00, 8'h00, 1);
    send("ov_prefix", 8'hF0, 8'h00, 8'h00, 1);
    check("ov_pre_valid", key_valid, 1'b1);
    clear_counts();
    ps2_overflow = 1'b1;
    q.push_back(8'h1C);
    n = 0;
    while (ps2_clrn && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ov_clrn_seen", ps2_clrn, 1'b0);
    ps2_overflow = 1'b0;
    repeat (10) @(negedge clk);
    check("ov_no_pop", 32'(pop_cnt), 32'd0);
    check("ov_clr_cycles", 32'(clr_low), 32'd4);
    check("ov_valid", key_valid, 1'b0);
    check("ov_count", press_count, 8'd5);
    check("ov_code_kept", key_code, 8'h1C);
    check("ov_seg", seg_select, 8'h30);
    clear_counts();
    send("ov_after", 8'h1C, 8'h00, 8'h00, 1);
    check("ov_brk_discarded", key_valid, 1'b1);
    check("ov_after_make", 32'(make_cnt), 32'd1);
    check("ov_after_count", press_count, 8'd6);

    // New make replaces held key; mismatched break ignored
    clear_counts();
    send("repl", 8'h1D, 8'h00, 8'h00, 1);
    check("repl_code", key_code, 8'h1D);
    check("repl_count", press_count, 8'd7);
    send("repl_mis", 8'hF0, 8'h1C, 8'h00, 2);
    check("repl_mis_valid", key_valid, 1'b1);
    check("repl_mis_break", 32'(break_cnt), 32'd0);
    send("repl_rel", 8'hF0, 8'h1D, 8'h00, 2);
    check("repl_rel_valid", key_valid, 1'b0);

    // Counter wrap: 249 more presses reach 0
    clear_counts();
    for (int i = 0; i < 249; i++) begin
      code = (i % 2 == 0) ? 8'h1C : 8'h1D;
      q.push_back(code);
      q.push_back(8'hF0);
      q.push_back(code);
      if (i == 247) begin
        drain("wrap_255");
        check("wrap_255", press_count, 8'hFF);
      end
    end
    drain("wrap_0");
    check("wrap_0", press_count, 8'h00);
    check("wrap_makes", 32'(make_cnt), 32'd249);
    check("wrap_valid", key_valid, 1'b0);

    // Reset during a pop aborts it cleanly
    clear_counts();
    q.push_back(8'h2A);
    n = 0;
    while (ps2_nextdata_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_pop_seen", ps2_nextdata_n, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_no_make", 32'(make_cnt), 32'd0);
    check("mid_valid", key_valid, 1'b0);
    check("mid_count", press_count, 8'd0);
    check("mid_code", key_code, 8'h00);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_make_after", 32'(make_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
